// File: rtl/wb_regfile.sv
// wb_regfile: MIPS writeback stage, 32x register file with write bypass, halt latch and cycle/retired counters
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic              wb_halt,
  input  logic              wb_we,
  input  logic [4:0]        wb_rw,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retired_cnt
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] regs_d [32];
  logic [CNT_W-1:0]  cycle_q, cycle_d, retired_q, retired_d;
  logic              run, commit;
  assign run    = state_q == RUN;
  // rst_n gates commit so a write presented while reset is held is neither stored nor bypassed
  assign commit = rst_n & run & wb_valid & wb_we & ~wb_halt & (wb_rw != 5'd0);
  assign rd1       = (commit && ra1 == wb_rw) ? wb_data : regs_q[ra1];
  assign rd2       = (commit && ra2 == wb_rw) ? wb_data : regs_q[ra2];
  assign dbg_data  = regs_q[dbg_addr];
  assign halted    = state_q == HALTED;
  assign cycle_cnt   = cycle_q;
  assign retired_cnt = retired_q;
  // next-state: register commit, halt transition, counters advance only while running
  always_comb begin
    regs_d = regs_q;
    if (commit) regs_d[wb_rw] = wb_data;
    state_d   = (run && wb_valid && wb_halt) ? HALTED : state_q;
    cycle_d   = run ? cycle_q + CNT_W'(1) : cycle_q;
    retired_d = (run && wb_valid) ? retired_q + CNT_W'(1) : retired_q;
  end
  // all architectural state; register 0 is never written so it stays 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cycle_q   <= '0;
      retired_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
      regs_q    <= regs_d;
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: randomized check of wb_regfile against a behavioural register-file model
module tb_wb_regfile;
  localparam int CW   = 4;
  localparam int MASK = (1 << CW) - 1;
  logic clk = 0, rst_n = 0;
  logic wb_valid = 0, wb_halt = 0, wb_we = 0;
  logic [4:0] wb_rw = 0, ra1 = 0, ra2 = 0, dbg_addr = 0;
  logic [31:0] wb_data = 0;
  logic [31:0] rd1, rd2, dbg_data;
  logic halted;
  logic [CW-1:0] cycle_cnt, retired_cnt;
  int checks = 0, errors = 0;
  logic [31:0] m_reg [32];
  bit m_halt;
  int m_cyc, m_ret;

  wb_regfile #(.DATA_W(32), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_halt(wb_halt), .wb_we(wb_we),
    .wb_rw(wb_rw), .wb_data(wb_data), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .halted(halted),
    .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_commit();
    return rst_n && !m_halt && wb_valid && wb_we && !wb_halt && wb_rw != 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    return (m_commit() && a == wb_rw) ? wb_data : m_reg[a];
  endfunction

  task automatic m_reset();
    foreach (m_reg[i]) m_reg[i] = 0;
    m_halt = 0; m_cyc = 0; m_ret = 0;
  endtask

  task automatic check_all();
    check("rd1", rd1, m_read(ra1));
    check("rd2", rd2, m_read(ra2));
    check("dbg", dbg_data, m_reg[dbg_addr]);
    check("halted", 32'(halted), 32'(m_halt));
    check("cycle", 32'(cycle_cnt), m_cyc & MASK);
    check("retired", 32'(retired_cnt), m_ret & MASK);
  endtask

  // check outputs mid-cycle, then advance the model over the rising edge
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    if (rst_n && !m_halt) begin
      if (m_commit()) m_reg[wb_rw] = wb_data;
      m_cyc++;
      if (wb_valid) begin
        m_ret++;
        if (wb_halt) m_halt = 1;
      end
    end
  endtask

  task automatic drive(input bit v, input bit h, input bit we, input logic [4:0] rw,
                       input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] da);
    wb_valid = v; wb_halt = h; wb_we = we; wb_rw = rw; wb_data = d;
    ra1 = a1; ra2 = a2; dbg_addr = da;
  endtask

  task automatic drive_rand(input bit allow_halt);
    logic [4:0] rw;
    rw = 5'($urandom);
    drive($urandom % 4 != 0, allow_halt && $urandom % 40 == 0, $urandom % 3 != 0, rw,
          $urandom, ($urandom % 3 == 0) ? rw : 5'($urandom),
          ($urandom % 3 == 0) ? rw : 5'($urandom), 5'($urandom));
  endtask

  // asynchronous reset pulse between clock edges
  task automatic reset_pulse();
    drive(0, 0, 0, 0, 0, 5'($urandom), 5'($urandom), 5'($urandom));
    rst_n = 0;
    #1;
    check("rst_rd1", rd1, 0);
    check("rst_dbg", dbg_data, 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_cycle", 32'(cycle_cnt), 0);
    check("rst_retired", 32'(retired_cnt), 0);
    m_reset();
    #1 rst_n = 1;
  endtask

  initial begin
    m_reset();
    repeat (2) step();
    rst_n = 1;
    drive(1, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0);
    #1 check("r0_nobypass", rd1, 0);
    step();
    check("r0_after", rd1, 0);
    drive(1, 0, 1, 5, 32'h12345678, 5, 5, 5);
    #1 check("byp_rd1", rd1, 32'h12345678);
    check("byp_rd2", rd2, 32'h12345678);
    check("byp_dbg_before", dbg_data, 0);
    step();
    check("dbg_after", dbg_data, 32'h12345678);
    drive(0, 0, 1, 7, 32'hFF, 7, 7, 7);
    #1 check("bubble_nobyp", rd1, 0);
    step();
    check("bubble_dbg", dbg_data, 0);
    check("bubble_retired", 32'(retired_cnt), 2);
    check("bubble_cycle", 32'(cycle_cnt), 3);
    repeat (200) begin
      drive_rand(0);
      step();
    end
    reset_pulse();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 5'(10 + i), $urandom, 5'(10 + i), 9, 9);
      step();
    end
    drive(1, 1, 1, 9, 32'hAAAA5555, 9, 9, 9);
    #1 check("halt_nobyp", rd1, 0);
    step();
    check("halt_halted", 32'(halted), 1);
    check("halt_retired", 32'(retired_cnt), 4);
    check("halt_dbg9", dbg_data, 0);
    repeat (5) begin
      drive(1, 0, 1, 2, $urandom, 2, 2, 2);
      step();
    end
    check("halted_r2", dbg_data, 0);
    check("halted_cycle", 32'(cycle_cnt), 4);
    drive(1, 0, 1, 3, 32'hCAFEF00D, 3, 3, 3);
    rst_n = 0;
    m_reset();
    step();
    check("rst_mid_r3", dbg_data, 0);
    check("rst_mid_halted", 32'(halted), 0);
    rst_n = 1;
    step();
    check("rel_commit", dbg_data, 32'hCAFEF00D);
    check("rel_retired", 32'(retired_cnt), 1);
    reset_pulse();
    repeat (16) step();
    check("cycle_wrap", 32'(cycle_cnt), 0);
    reset_pulse();
    drive(1, 0, 0, 4, 32'h1, 4, 4, 4);
    repeat (17) step();
    check("retired_wrap", 32'(retired_cnt), 1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom % 80 == 0) reset_pulse();
      drive_rand(1);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
